writeback_unit: RTL
===================

// Module: writeback_unit
// PURPOSE
//  Parametrised writeback stage holding the MEM/WB pipeline register for the OTTER pipeline.
//  Performs load byte/half/word alignment with sign/zero extension and selects the
//  register-file write source. Drives the RF write port, a registered WB->EX forward bus,
//  a retired-instruction counter and a sticky misaligned-load error.
// PARAMETERS
//  XLEN     32  datapath width; must be 32 or 64 (elaboration $error otherwise)
//  RADDR_W  5   register address width
//  CNT_W    64  INSTRET counter width
//  FWD_EN   1   1: build forward register; 0: FWD_* tied to 0
// PORTS
//  WB_CLK            in   1        clock, rising edge
//  WB_RST            in   1        asynchronous, active-high reset
//  WB_STALL          in   1        hold stage; no commit this cycle
//  WB_FLUSH          in   1        load bubble at next edge
//  MEM_VALID         in   1        MEM-stage instruction valid
//  MEM_REG_WRITE     in   1        instruction writes rd
//  MEM_RD            in   RADDR_W  destination register
//  MEM_RF_WR_SEL     in   2        0=PC+4 1=CSR 2=load data 3=ALU
//  MEM_SIZE          in   2        00=byte 01=half 10=word 11=dword (XLEN=64 only)
//  MEM_UNSIGNED      in   1        zero-extend load
//  MEM_PC_PLUS_FOUR  in   XLEN     PC+4 of instruction
//  MEM_CSR_REG       in   XLEN     CSR read value
//  MEM_ALU_RESULT    in   XLEN     ALU result / load address
//  D_OUT_2           in   XLEN     raw memory word; valid in the WB cycle, unregistered
//  RF_WE             out  1        register-file write enable
//  RF_WA             out  RADDR_W  register-file write address
//  WD                out  XLEN     register-file write data
//  FWD_VALID         out  1        last-cycle commit is forwardable
//  FWD_RD            out  RADDR_W  last-cycle committed rd
//  FWD_DATA          out  XLEN     last-cycle committed data
//  INSTRET           out  CNT_W    retired-instruction count
//  ERR_MISALIGN      out  1        sticky misaligned-load flag
//  ERR_PC            out  XLEN     PC (PC+4 minus 4) of first misaligned load
// BEHAVIOUR
//  Reset (async): wb_valid, all pipeline fields, FWD_*, INSTRET, ERR_* = 0; RF_WE=0, WD=0.
//  Edge priority: WB_FLUSH > WB_STALL > capture. Flush: wb_valid<=0, other fields don't-care.
//    Stall: all fields hold. Otherwise capture MEM_* (wb_valid<=MEM_VALID).
//  commit = wb_valid & ~WB_STALL. RF_WE = commit & reg_write & (rd!=0); comb, same cycle.
//  Latency: MEM_* captured at edge N, WD/RF_WE valid in cycle N+1, RF writes at edge N+1.
//  WD mux from registered sel; sel=2 uses aligned D_OUT_2 (current cycle value).
//  Alignment: off = alu_result[$clog2(XLEN/8)-1:0]. Byte: lane off, extend bit 7.
//    Half: lane off&~1, extend bit 15. Word: lane off&~3, extend bit 31 (XLEN=64). Dword: raw.
//    Misaligned: half off[0]=1; word off[1:0]!=0; dword off!=0; size 11 with XLEN=32.
//    Misaligned loads still commit using the truncated lane (XLEN=32 size 11 -> word).
//  Error: on commit of a misaligned load with ERR_MISALIGN=0, set it and ERR_PC<=pc_plus_four-4.
//    Later misaligned loads leave ERR_PC unchanged; cleared only by reset.
//  INSTRET += 1 on each commit, including rd=0 and non-writing instructions; wraps mod 2^CNT_W.
//  Forward register (FWD_EN=1), at each edge: FWD_VALID<=RF_WE, FWD_RD<=RF_WA, FWD_DATA<=WD.
//    With RF_WE=0 FWD_VALID<=0, FWD_RD/FWD_DATA hold.
//  Flush while stalled discards the held instruction (no commit, no INSTRET).
//  Reset mid-stall drops the instruction; no write occurs in the reset cycle.
// STRUCTURE
//  Package otter_wb_pkg: enum wr_sel_t {WR_PC4, WR_CSR, WR_MEM, WR_ALU};
//    enum mem_size_t {SZ_B, SZ_H, SZ_W, SZ_D}; struct wb_fields_t (pipeline register bundle).
//  Sub-module load_align #(XLEN): combinational; (word, off, size, unsigned) -> data, misalign.
// TESTING
//  Byte: ALU=0x1003, D_OUT_2=0x80FF_1234, signed LB -> WD=0xFFFF_FF80, RF_WE=1, one cycle later.
//  Half/unsigned: LHU at off 2, word 0x8001_0000 -> WD=0x0000_8001; LH at off 1 -> ERR_MISALIGN=1.
//  Stall: ALU op rd=5 stalled 3 cycles -> RF_WE=0 during stall; one write on release; INSTRET +1.
//  Flush+stall same cycle -> bubble; RF_WE=0; INSTRET unchanged; FWD_VALID=0 next cycle.
//  rd=0 with REG_WRITE=1 -> RF_WE=0, INSTRET increments, FWD_VALID=0.
//  Async reset asserted mid-cycle with valid stage -> all outputs 0 immediately; CNT_W=4 wraps 15->0.

Source files
------------

// File: rtl/otter_wb_pkg.sv
// Shared types for the OTTER writeback stage: write-source and load-size
// encodings plus the control half of the MEM/WB pipeline register.
package otter_wb_pkg;

    typedef enum logic [1:0] {
        WR_PC4 = 2'd0,
        WR_CSR = 2'd1,
        WR_MEM = 2'd2,
        WR_ALU = 2'd3
    } wr_sel_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    // Control bits of the pipeline register; the width-parametrised payload
    // (rd, PC+4, CSR, ALU) lives beside it in the top module.
    typedef struct packed {
        logic      valid;
        logic      reg_write;
        wr_sel_t   wr_sel;
        mem_size_t size;
        logic      is_unsigned;
    } wb_fields_t;

    localparam wb_fields_t WB_FIELDS_RESET = '{
        valid:       1'b0,
        reg_write:   1'b0,
        wr_sel:      WR_PC4,
        size:        SZ_B,
        is_unsigned: 1'b0
    };

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/half/word lane out of
// the raw memory word, sign- or zero-extends it, and flags misalignment.
module load_align
    import otter_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           word,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  mem_size_t                 size,
    input  logic                      is_unsigned,
    output logic [XLEN-1:0]           data,
    output logic                      misalign
);

    localparam int OFF_W = $clog2(XLEN/8);

    logic [OFF_W-1:0] lane_h;
    logic [OFF_W-1:0] lane_w;
    logic [XLEN-1:0]  sh_b;
    logic [XLEN-1:0]  sh_h;
    logic [XLEN-1:0]  sh_w;

    // Misaligned halves/words fall back to the enclosing aligned lane.
    assign lane_h = off & ~OFF_W'(1);
    assign lane_w = off & ~OFF_W'(3);

    assign sh_b = word >> {off,    3'b000};
    assign sh_h = word >> {lane_h, 3'b000};
    assign sh_w = word >> {lane_w, 3'b000};

    // Extend the selected lane and evaluate the alignment rule for the size.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned and infers a latch.
        data     = '0;
        misalign = 1'b0;
        case (size)
            SZ_B: begin
                if (is_unsigned) data = XLEN'(sh_b[7:0]);
                else             data = XLEN'($signed(sh_b[7:0]));
            end
            SZ_H: begin
                if (is_unsigned) data = XLEN'(sh_h[15:0]);
                else             data = XLEN'($signed(sh_h[15:0]));
                misalign = off[0];
            end
            SZ_W: begin
                // With XLEN=32 the lane is always 0 and the extension is a no-op.
                if (is_unsigned) data = XLEN'(sh_w[31:0]);
                else             data = XLEN'($signed(sh_w[31:0]));
                misalign = (off[1:0] != 2'b00);
            end
            SZ_D: begin
                // A dword on a 32-bit datapath degrades to a plain word load.
                data     = (XLEN == 64) ? word : sh_w;
                misalign = (XLEN == 64) ? (off != '0) : 1'b1;
            end
            default: begin
                data     = '0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// OTTER writeback stage: MEM/WB pipeline register, write-source selection,
// register-file write port, WB->EX forward register, INSTRET and a sticky
// misaligned-load error capture.
module writeback_unit
    import otter_wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64,
    parameter int FWD_EN  = 1
) (
    input  logic               WB_CLK,
    input  logic               WB_RST,
    input  logic               WB_STALL,
    input  logic               WB_FLUSH,
    input  logic               MEM_VALID,
    input  logic               MEM_REG_WRITE,
    input  logic [RADDR_W-1:0] MEM_RD,
    input  logic [1:0]         MEM_RF_WR_SEL,
    input  logic [1:0]         MEM_SIZE,
    input  logic               MEM_UNSIGNED,
    input  logic [XLEN-1:0]    MEM_PC_PLUS_FOUR,
    input  logic [XLEN-1:0]    MEM_CSR_REG,
    input  logic [XLEN-1:0]    MEM_ALU_RESULT,
    input  logic [XLEN-1:0]    D_OUT_2,
    output logic               RF_WE,
    output logic [RADDR_W-1:0] RF_WA,
    output logic [XLEN-1:0]    WD,
    output logic               FWD_VALID,
    output logic [RADDR_W-1:0] FWD_RD,
    output logic [XLEN-1:0]    FWD_DATA,
    output logic [CNT_W-1:0]   INSTRET,
    output logic               ERR_MISALIGN,
    output logic [XLEN-1:0]    ERR_PC
);

    localparam int OFF_W = $clog2(XLEN/8);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("writeback_unit: XLEN must be 32 or 64, got %0d", XLEN);
    end

    wb_fields_t         ctl;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    pc_plus_four;
    logic [XLEN-1:0]    csr_reg;
    logic [XLEN-1:0]    alu_result;

    logic               commit;
    logic               load_misalign;
    logic [XLEN-1:0]    load_data;

    // MEM/WB register: flush beats stall beats capture.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            ctl          <= WB_FIELDS_RESET;
            rd           <= '0;
            pc_plus_four <= '0;
            csr_reg      <= '0;
            alu_result   <= '0;
        end else if (WB_FLUSH) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ctl.valid <= 1'b0;
        end else if (!WB_STALL) begin
            ctl.valid       <= MEM_VALID;
            ctl.reg_write   <= MEM_REG_WRITE;
            ctl.wr_sel      <= wr_sel_t'(MEM_RF_WR_SEL);
            ctl.size        <= mem_size_t'(MEM_SIZE);
            ctl.is_unsigned <= MEM_UNSIGNED;
            rd              <= MEM_RD;
            pc_plus_four    <= MEM_PC_PLUS_FOUR;
            csr_reg         <= MEM_CSR_REG;
            alu_result      <= MEM_ALU_RESULT;
        end
    end

    // Memory data arrives unregistered during the WB cycle itself.
    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .word        (D_OUT_2),
        .off         (alu_result[OFF_W-1:0]),
        .size        (ctl.size),
        .is_unsigned (ctl.is_unsigned),
        .data        (load_data),
        .misalign    (load_misalign)
    );

    assign commit = ctl.valid & ~WB_STALL;
    assign RF_WE  = commit & ctl.reg_write & (rd != '0);
    assign RF_WA  = rd;

    // Register-file write-data mux driven by the registered source select.
    always_comb begin
        WD = '0;
        case (ctl.wr_sel)
            WR_PC4:  WD = pc_plus_four;
            WR_CSR:  WD = csr_reg;
            WR_MEM:  WD = load_data;
            WR_ALU:  WD = alu_result;
            default: WD = '0;
        endcase
    end

    // Retired-instruction counter; counts every commit and wraps freely.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            INSTRET <= '0;
        end else if (commit) begin
            INSTRET <= INSTRET + CNT_W'(1);
        end
    end

    // Sticky error: remember the PC of the first misaligned load only.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            ERR_MISALIGN <= 1'b0;
            ERR_PC       <= '0;
        end else if (commit && ctl.wr_sel == WR_MEM && load_misalign && !ERR_MISALIGN) begin
            ERR_MISALIGN <= 1'b1;
            ERR_PC       <= pc_plus_four - XLEN'(4);
        end
    end

    if (FWD_EN != 0) begin : g_fwd
        // Forward register: valid tracks the write, rd/data hold when idle.
        always_ff @(posedge WB_CLK or posedge WB_RST) begin
            if (WB_RST) begin
                FWD_VALID <= 1'b0;
                FWD_RD    <= '0;
                FWD_DATA  <= '0;
            end else begin
                FWD_VALID <= RF_WE;
                if (RF_WE) begin
                    FWD_RD   <= RF_WA;
                    FWD_DATA <= WD;
                end
            end
        end
    end else begin : g_no_fwd
        assign FWD_VALID = 1'b0;
        assign FWD_RD    = '0;
        assign FWD_DATA  = '0;
    end

endmodule
